// File: rtl/seven_segment_marquee.sv
// seven_segment_marquee
//   Multi-digit seven-segment message driver. A message of glyph codes is
//   written through a valid/ready port, then shown statically or as a
//   scrolling marquee across NUM_DIGITS time-multiplexed active-low digits.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous message clear (wins over a same-cycle write)
//   wr_valid   write beat valid
//   wr_ready   write beat accepted when wr_valid & wr_ready at rising clk
//   wr_data    [5] decimal point on, [4:0] glyph code
//   wr_last    final character of the message
//   scroll_en  1 = marquee scroll, 0 = static view
//   msg_len    stored character count
//   seg        active-low {a,b,c,d,e,f,g,dp}, registered
//   an         active-low one-hot digit enable, registered; an[0] = rightmost
module seven_segment_marquee #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 16,
  parameter int MUX_DIV    = 50000,
  parameter int SCROLL_DIV = 12500000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [5:0]                     wr_data,
  input  logic                           wr_last,
  input  logic                           scroll_en,
  output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
  output logic [7:0]                     seg,
  output logic [NUM_DIGITS-1:0]          an
);

  localparam int CW = $clog2(MSG_DEPTH + 1);
  localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int JW = CW + DW + 1;

  typedef enum logic [1:0] {EMPTY, LOAD, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           off_q, off_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [MW-1:0]           mux_cnt_q, mux_cnt_d;
  logic [SW-1:0]           scr_cnt_q, scr_cnt_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [5:0]              buf_q [MSG_DEPTH];

  logic                    accept;
  logic [JW-1:0]           win_idx;
  logic                    in_msg;
  logic [IW-1:0]           rd_idx;
  logic [5:0]              rd_char;

  // Active-low abcdefg pattern for a 5-bit glyph code.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'b0000001;
      5'd1:    glyph = 7'b1001111;
      5'd2:    glyph = 7'b0010010;
      5'd3:    glyph = 7'b0000110;
      5'd4:    glyph = 7'b1001100;
      5'd5:    glyph = 7'b0100100;
      5'd6:    glyph = 7'b0100000;
      5'd7:    glyph = 7'b0001111;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0000100;
      5'd10:   glyph = 7'b0001000;
      5'd11:   glyph = 7'b1100000;
      5'd12:   glyph = 7'b0110001;
      5'd13:   glyph = 7'b1000010;
      5'd14:   glyph = 7'b0110000;
      5'd15:   glyph = 7'b0111000;
      5'd16:   glyph = 7'b1001000;
      5'd17:   glyph = 7'b1110001;
      5'd18:   glyph = 7'b0011000;
      5'd19:   glyph = 7'b1000001;
      5'd20:   glyph = 7'b1111010;
      5'd21:   glyph = 7'b1101010;
      5'd22:   glyph = 7'b1111110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign wr_ready = (state_q != SHOW) && !clr;
  assign accept   = wr_valid && wr_ready;

  // Character under the digit being scanned. Digit d is window position
  // NUM_DIGITS-1-d counted from the left; positions past the message blank.
  always_comb begin
    win_idx = JW'(off_q) + JW'(DW'(NUM_DIGITS - 1) - digit_q);
    in_msg  = win_idx < JW'(count_q);
    rd_idx  = in_msg ? win_idx[IW-1:0] : '0;
    rd_char = buf_q[rd_idx];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    off_d     = off_q;
    digit_d   = digit_q;
    mux_cnt_d = mux_cnt_q;
    scr_cnt_d = scr_cnt_q;
    seg_d     = 8'hFF;
    an_d      = '1;

    // Outputs follow the current state, so a clear darkens them one edge
    // after the state itself returns to EMPTY.
    if (state_q == SHOW) begin
      seg_d = in_msg ? {glyph(rd_char[4:0]), ~rd_char[5]} : 8'hFF;
      an_d  = ~(NUM_DIGITS'(1) << digit_q);
    end

    if (clr) begin
      state_d   = EMPTY;
      count_d   = '0;
      off_d     = '0;
      digit_d   = '0;
      mux_cnt_d = '0;
      scr_cnt_d = '0;
    end else begin
      case (state_q)
        EMPTY, LOAD: begin
          // Scan and scroll sit at zero so SHOW always starts from digit 0.
          off_d     = '0;
          digit_d   = '0;
          mux_cnt_d = '0;
          scr_cnt_d = '0;
          if (accept) begin
            count_d = count_q + 1'b1;
            state_d = (wr_last || count_d == CW'(MSG_DEPTH)) ? SHOW : LOAD;
          end
        end
        SHOW: begin
          if (mux_cnt_q == MW'(MUX_DIV - 1)) begin
            mux_cnt_d = '0;
            digit_d   = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
          end else begin
            mux_cnt_d = mux_cnt_q + 1'b1;
          end
          if (!scroll_en) begin
            scr_cnt_d = '0;
            off_d     = '0;
          end else if (scr_cnt_q == SW'(SCROLL_DIV - 1)) begin
            scr_cnt_d = '0;
            off_d     = (off_q + 1'b1 >= count_q) ? '0 : off_q + 1'b1;
          end else begin
            scr_cnt_d = scr_cnt_q + 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      count_q   <= '0;
      off_q     <= '0;
      digit_q   <= '0;
      mux_cnt_q <= '0;
      scr_cnt_q <= '0;
      seg_q     <= 8'hFF;
      an_q      <= '1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      off_q     <= off_d;
      digit_q   <= digit_d;
      mux_cnt_q <= mux_cnt_d;
      scr_cnt_q <= scr_cnt_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  // Message storage is pure data; the count qualifies which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) buf_q[count_q[IW-1:0]] <= wr_data;
  end

  assign msg_len = count_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_seven_segment_marquee.sv
module tb_seven_segment_marquee;
  localparam int ND   = 4;
  localparam int MD   = 8;
  localparam int MUXD = 2;
  localparam int SCRD = 8;

  logic       clk = 1'b0;
  logic       rst, clr, wr_valid, wr_ready, wr_last, scroll_en;
  logic [5:0] wr_data;
  logic [3:0] msg_len;
  logic [7:0] seg;
  logic [3:0] an;

  seven_segment_marquee #(
    .NUM_DIGITS(ND), .MSG_DEPTH(MD), .MUX_DIV(MUXD), .SCROLL_DIV(SCRD)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .scroll_en(scroll_en),
    .msg_len(msg_len), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] msg[$];

  logic [6:0] glyph_tab [32] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1001000, 7'b1110001,
    7'b0011000, 7'b1000001, 7'b1111010, 7'b1101010, 7'b1111110, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Expected {an, seg} t cycles after the edge that entered SHOW.
  function automatic logic [11:0] exp_out(input int t, input bit scr);
    int         len = msg.size();
    int         dig = ((t - 1) / MUXD) % ND;
    int         off = scr ? ((t - 1) / SCRD) % len : 0;
    int         j   = off + (ND - 1 - dig);
    logic [5:0] c;
    logic [7:0] s = 8'hFF;
    logic [3:0] a = 4'hF;
    if (j < len) begin
      c = msg[j];
      s = {glyph_tab[c[4:0]], ~c[5]};
    end
    a[dig] = 1'b0;
    return {a, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Write the first n characters of msg with random idle gaps.
  task automatic load_msg(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      wr_valid = 1'b1;
      wr_data  = msg[i];
      wr_last  = use_last && (i == n - 1);
      #1;
      check("ready_load", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
    end
  endtask

  // Watch the display while junk writes must be refused.
  task automatic observe(input int cycles, input bit scr);
    for (int t = 1; t <= cycles; t++) begin
      wr_valid = 1'($urandom);
      wr_data  = 6'($urandom);
      wr_last  = 1'($urandom);
      #1;
      check("ready_show", wr_ready, 1'b0);
      tick();
      check("display", {an, seg}, exp_out(t, scr));
      check("msg_len", msg_len, msg.size());
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic run_msg(input bit scr, input bit use_last, input int cycles);
    scroll_en = scr;
    do_clr();
    check("len_clr", msg_len, 0);
    load_msg(msg.size(), use_last);
    observe(cycles, scr);
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(6'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wr_data = '0; scroll_en = 1'b0;
    #1;
    check("rst_seg", seg, 8'hFF);
    check("rst_an", an, 4'hF);
    check("rst_len", msg_len, 0);
    check("rst_ready", wr_ready, 1'b1);
    tick();
    rst = 1'b0;

    // "dUdE", static
    msg = '{6'd13, 6'd19, 6'd13, 6'd14};
    run_msg(1'b0, 1'b1, 16);
    // "H2.0" short message, rightmost digit blank
    msg = '{6'd16, 6'b100010, 6'd0};
    run_msg(1'b0, 1'b1, 16);
    // full buffer without wr_last terminates by itself
    rand_msg(MD);
    run_msg(1'b0, 1'b0, 16);
    // "123456" scrolling through a full wrap
    msg = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    run_msg(1'b1, 1'b1, 64);

    // random messages
    repeat (10) begin
      len = $urandom_range(1, MD);
      rand_msg(len);
      run_msg(1'($urandom), (len < MD) ? 1'b1 : 1'($urandom), $urandom_range(20, 80));
    end

    // clr in SHOW beats a simultaneous write
    clr = 1'b1; wr_valid = 1'b1; wr_data = 6'd5; wr_last = 1'b1;
    #1;
    check("clr_ready", wr_ready, 1'b0);
    tick();
    check("clr_len", msg_len, 0);
    clr = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    #1;
    check("clr_ready_after", wr_ready, 1'b1);
    tick();
    check("clr_seg", seg, 8'hFF);
    check("clr_an", an, 4'hF);
    check("clr_len_after", msg_len, 0);

    // asynchronous reset mid-LOAD
    rand_msg(MD);
    load_msg(3, 1'b0);
    check("load3_len", msg_len, 3);
    #2 rst = 1'b1;
    #1;
    check("rstload_seg", seg, 8'hFF);
    check("rstload_an", an, 4'hF);
    check("rstload_len", msg_len, 0);
    tick();
    rst = 1'b0;
    rand_msg(5);
    scroll_en = 1'b1;
    load_msg(5, 1'b1);
    observe(48, 1'b1);

    // asynchronous reset mid-SHOW darkens at once
    #2 rst = 1'b1;
    #1;
    check("rstshow_seg", seg, 8'hFF);
    check("rstshow_an", an, 4'hF);
    check("rstshow_len", msg_len, 0);
    check("rstshow_ready", wr_ready, 1'b1);
    tick();
    rst = 1'b0;
    rand_msg(2);
    scroll_en = 1'b0;
    load_msg(2, 1'b1);
    observe(16, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
